// File: rtl/pass_pkg.sv
// Shared types and helpers for the password-lock digit entry path.
package pass_pkg;

  localparam int DIGITS_DEF = 4;
  localparam int DW_DEF     = 4;

  // Entry buffer control states: normal operation or stepped clear.
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } pe_state_t;

  // Width of a counter that must hold 0..digits inclusive.
  function automatic int cnt_w(input int digits);
    return $clog2(digits + 1);
  endfunction

endpackage

// File: rtl/pass_entry_buf_key_rise.sv
// Rising-edge detector for keypad level signals; one pulse per high period.
module key_rise (
  input  logic rst,
  input  logic clk,
  input  logic lvl,
  output logic pulse
);

  logic lvl_q;

  // Remember last cycle's level so a held key yields a single pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lvl_q <= 1'b0;
    else      lvl_q <= lvl;
  end

  assign pulse = lvl & ~lvl_q;

endmodule

// File: rtl/pass_entry_buf.sv
// Digit-entry buffer for the password lock: collects keypad digits with
// backspace, clear (single-cycle or stepped) and commit to the password.
module pass_entry_buf
  import pass_pkg::*;
#(
  parameter int DIGITS     = DIGITS_DEF,
  parameter int DW         = DW_DEF,
  parameter int CLEAR_STEP = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_en,
  input  logic [DW-1:0]             key_val,
  input  logic                      bksp,
  input  logic                      clear,
  input  logic                      commit,
  output logic [DIGITS*DW-1:0]      entry,
  output logic [DIGITS*DW-1:0]      password,
  output logic [cnt_w(DIGITS)-1:0]  count,
  output logic                      full,
  output logic                      busy,
  output logic                      commit_ok,
  output logic                      err,
  output logic                      dbg_state
);

  localparam int CW = cnt_w(DIGITS);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] MAX = CW'(DIGITS);

  pe_state_t              state, state_n;
  logic [DIGITS*DW-1:0]   entry_n, password_n;
  logic [CW-1:0]          count_n;
  logic                   commit_ok_n, err_n;
  logic                   press;

  key_rise u_key_rise (
    .rst   (rst),
    .clk   (clk),
    .lvl   (key_en),
    .pulse (press)
  );

  // Register FSM state, the entry shift register and all pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      entry     <= '0;
      count     <= '0;
      password  <= '0;
      commit_ok <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      entry     <= entry_n;
      count     <= count_n;
      password  <= password_n;
      commit_ok <= commit_ok_n;
      err       <= err_n;
    end
  end

  // Next-state and action decode; one action per cycle, clear > commit > bksp > press.
  always_comb begin
    state_n     = state;
    entry_n     = entry;
    count_n     = count;
    password_n  = password;
    commit_ok_n = 1'b0;
    err_n       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear) begin
          if (CLEAR_STEP == 0) begin
            entry_n = '0;
            count_n = '0;
          end else if (count != '0) begin
            state_n = ST_CLEARING;
          end
        end else if (commit) begin
          if (count == MAX) begin
            password_n  = entry;
            entry_n     = '0;
            count_n     = '0;
            commit_ok_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else if (bksp) begin
          if (count != '0) begin
            entry_n = entry >> DW;
            count_n = count - ONE;
          end else begin
            err_n = 1'b1;
          end
        end else if (press) begin
          if (count != MAX) begin
            entry_n = {entry[(DIGITS-1)*DW-1:0], key_val};
            count_n = count + ONE;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_CLEARING: begin
        // Drop the newest digit each cycle; leave when the last one goes.
        entry_n = entry >> DW;
        if (count != '0) count_n = count - ONE;
        if (count <= ONE) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign full      = (count == MAX);
  assign busy      = (state == ST_CLEARING);
  assign dbg_state = state;

endmodule

// File: tb/tb_pass_entry_buf.sv
// Bench for pass_entry_buf (DIGITS=4, DW=4, CLEAR_STEP=1): directed steps
// followed by random traffic, each cycle compared with a digit-queue model.
module tb_pass_entry_buf;

  logic        clk;
  logic        rst;
  logic        key_en;
  logic [3:0]  key_val;
  logic        bksp, clear, commit;
  logic [15:0] entry, password;
  logic [2:0]  count;
  logic        full, busy, commit_ok, err, dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model state: digits oldest-first, committed password, clear flag.
  logic [3:0]  digs[$];
  logic [15:0] m_pw;
  logic        m_clearing;
  logic        m_prev_key;
  logic        m_ok, m_err;

  pass_entry_buf #(.DIGITS(4), .DW(4), .CLEAR_STEP(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_en    (key_en),
    .key_val   (key_val),
    .bksp      (bksp),
    .clear     (clear),
    .commit    (commit),
    .entry     (entry),
    .password  (password),
    .count     (count),
    .full      (full),
    .busy      (busy),
    .commit_ok (commit_ok),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_entry();
    logic [15:0] e;
    e = '0;
    foreach (digs[i]) e = {e[11:0], digs[i]};
    return e;
  endfunction

  task automatic model_reset();
    digs.delete();
    m_pw       = '0;
    m_clearing = 1'b0;
    m_prev_key = 1'b0;
    m_ok       = 1'b0;
    m_err      = 1'b0;
  endtask

  // Apply one clock edge's worth of the behavioural rules to the model.
  task automatic model_step(input logic ke, input logic [3:0] kv,
                            input logic b, input logic c, input logic cm);
    logic press;
    press      = ke && !m_prev_key;
    m_prev_key = ke;
    m_ok       = 1'b0;
    m_err      = 1'b0;
    if (m_clearing) begin
      if (digs.size() > 0) void'(digs.pop_back());
      if (digs.size() == 0) m_clearing = 1'b0;
    end else if (c) begin
      if (digs.size() > 0) m_clearing = 1'b1;
    end else if (cm) begin
      if (digs.size() == 4) begin
        m_pw = model_entry();
        digs.delete();
        m_ok = 1'b1;
      end else m_err = 1'b1;
    end else if (b) begin
      if (digs.size() > 0) void'(digs.pop_back());
      else m_err = 1'b1;
    end else if (press) begin
      if (digs.size() < 4) digs.push_back(kv);
      else m_err = 1'b1;
    end
  endtask

  task automatic check_model();
    check("entry",     32'(entry),     32'(model_entry()));
    check("count",     32'(count),     32'(digs.size()));
    check("full",      32'(full),      32'(digs.size() == 4));
    check("busy",      32'(busy),      32'(m_clearing));
    check("dbg_state", 32'(dbg_state), 32'(m_clearing));
    check("password",  32'(password),  32'(m_pw));
    check("commit_ok", 32'(commit_ok), 32'(m_ok));
    check("err",       32'(err),       32'(m_err));
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic cyc(input logic ke, input logic [3:0] kv,
                     input logic b, input logic c, input logic cm);
    key_en = ke; key_val = kv; bksp = b; clear = c; commit = cm;
    @(posedge clk);
    #1;
    model_step(ke, kv, b, c, cm);
    check_model();
  endtask

  task automatic press_key(input logic [3:0] v);
    cyc(1'b1, v, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, v, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic ke_r;
    key_en = 0; key_val = 0; bksp = 0; clear = 0; commit = 0;
    rst = 1'b0;
    model_reset();
    #12;
    check("rst_entry", 32'(entry), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check_model();
    rst = 1'b1;
    @(posedge clk); #1;

    // Four presses fill the entry; a fifth is rejected.
    press_key(4'h1); press_key(4'h2); press_key(4'h3); press_key(4'h4);
    check("fill_entry", 32'(entry), 32'h1234);
    check("fill_full",  32'(full),  32'h1);
    cyc(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    check("over_err",   32'(err),   32'h1);
    check("over_entry", 32'(entry), 32'h1234);
    idle();

    // Commit a full entry.
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    check("commit_pw", 32'(password),  32'h1234);
    check("commit_ok", 32'(commit_ok), 32'h1);
    check("commit_en", 32'(entry),     32'h0);
    idle();

    // Held key captures only one digit.
    for (int i = 0; i < 10; i++) cyc(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    idle();
    check("hold_entry", 32'(entry), 32'h0007);

    // Backspace behaviour, including underflow.
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    press_key(4'h1); press_key(4'h2);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("bksp_entry", 32'(entry), 32'h0001);
    check("bksp_count", 32'(count), 32'h1);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("bksp_empty_err", 32'(err), 32'h1);

    // Commit with three digits is refused.
    press_key(4'h1); press_key(4'h2); press_key(4'h3);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    check("short_commit_err", 32'(err),      32'h1);
    check("short_commit_pw",  32'(password), 32'h1234);
    check("short_commit_en",  32'(entry),    32'h0123);

    // Stepped clear; a press during busy is dropped.
    press_key(4'h4);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    check("clr_busy0", 32'(busy), 32'h1);
    cyc(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    check("clr_step1", 32'(entry), 32'h0123);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("clr_step2", 32'(entry), 32'h0012);
    idle();
    check("clr_step3", 32'(entry), 32'h0001);
    idle();
    check("clr_step4", 32'(entry), 32'h0000);
    check("clr_done",  32'(busy),  32'h0);

    // Clear wins over commit and press; then reset lands mid-clear.
    press_key(4'h1); press_key(4'h2); press_key(4'h3); press_key(4'h4);
    cyc(1'b1, 4'h5, 1'b0, 1'b1, 1'b1);
    check("prio_busy", 32'(busy),      32'h1);
    check("prio_ok",   32'(commit_ok), 32'h0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst_entry", 32'(entry),    32'h0);
    check("arst_pw",    32'(password), 32'h0);
    check("arst_busy",  32'(busy),     32'h0);
    check_model();
    #3 rst = 1'b1;
    @(posedge clk); #1;
    check_model();

    // Random traffic against the model.
    ke_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 4) ke_r = ~ke_r;
      cyc(ke_r, 4'($urandom_range(0, 15)),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 6) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
